// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg: run-state encoding, level width and move-rate defaults shared by
// the scheduler and the sprite animators.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package game_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_OVER = 2'd2
   } run_state_t;

   localparam int LEVEL_W = 4;

   localparam int DEF_PERIOD_W        = 20;
   localparam int DEF_INIT_PERIOD     = 500000;
   localparam int DEF_MIN_PERIOD      = 100000;
   localparam int DEF_PERIOD_STEP     = 25000;
   localparam int DEF_MOVES_PER_LEVEL = 640;
   localparam int DEF_LEVEL_MAX       = 15;

   // Shorter period for the next level, clamped so it never drops below the floor.
   function automatic int unsigned dec_period(input int unsigned p,
                                              input int unsigned min_p,
                                              input int unsigned step);
      if (p < min_p + step) begin
         return min_p;
      end
      return p - step;
   endfunction

endpackage

`default_nettype wire

// File: rtl/move_scheduler_if.sv
// ---------------------------------------------------------------------------
// move_scheduler_if: game-control inputs and move/status outputs of the
// scheduler.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface move_scheduler_if;
   import game_pkg::*;

   logic               start;
   logic               collision;
   logic               move;
   logic               running;
   logic               game_over;
   logic [LEVEL_W-1:0] level;

   modport slave (
      input  start,
      input  collision,
      output move,
      output running,
      output game_over,
      output level
   );

   modport master (
      output start,
      output collision,
      input  move,
      input  running,
      input  game_over,
      input  level
   );

endinterface

`default_nettype wire

// File: rtl/move_tick_gen.sv
// ---------------------------------------------------------------------------
// move_tick_gen: free-running cycle counter emitting a registered one-cycle
// tick every period_i enabled cycles.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module move_tick_gen #(
   parameter int PERIOD_W = 20
) (
   input  wire logic                clk,
   input  wire logic                reset,
   input  wire logic                enable_i,
   input  wire logic                clear_i,
   input  wire logic [PERIOD_W-1:0] period_i,
   output logic                     tick_o,
   output logic                     wrap_o
);

   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic                tick_q, tick_d;
   logic [PERIOD_W-1:0] last_cnt;

   assign last_cnt = period_i - PERIOD_W'(1);
   // wrap_o lets the owner update level/period on the same edge the tick is issued.
   assign wrap_o   = enable_i & ~clear_i & (cnt_q >= last_cnt);

   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (clear_i) begin
         cnt_d = '0;
      end else if (wrap_o) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end else if (enable_i) begin
         cnt_d = cnt_q + PERIOD_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;

endmodule

`default_nettype wire

// File: rtl/move_scheduler.sv
// ---------------------------------------------------------------------------
// move_scheduler: game run-state FSM issuing move pulses whose rate ramps up
// with the level counter.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module move_scheduler
   import game_pkg::*;
#(
   parameter int PERIOD_W        = DEF_PERIOD_W,
   parameter int INIT_PERIOD     = DEF_INIT_PERIOD,
   parameter int MIN_PERIOD      = DEF_MIN_PERIOD,
   parameter int PERIOD_STEP     = DEF_PERIOD_STEP,
   parameter int MOVES_PER_LEVEL = DEF_MOVES_PER_LEVEL,
   parameter int LEVEL_MAX       = DEF_LEVEL_MAX
) (
   input  wire logic         clk,
   input  wire logic         reset,
   move_scheduler_if.slave   bus
);

   localparam int MCNT_W = $clog2(MOVES_PER_LEVEL + 1);

   localparam logic [PERIOD_W-1:0] PERIOD_INIT = PERIOD_W'(INIT_PERIOD);
   localparam logic [MCNT_W-1:0]   MCNT_LAST   = MCNT_W'(MOVES_PER_LEVEL - 1);
   localparam logic [LEVEL_W-1:0]  LEVEL_TOP   = LEVEL_W'(LEVEL_MAX);

   run_state_t          state_q, state_d;
   logic                start_q;
   logic [LEVEL_W-1:0]  level_q, level_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [MCNT_W-1:0]   mcnt_q, mcnt_d;

   logic start_rise;
   logic reinit;
   logic tick_en;
   logic tick;
   logic wrap;

   assign start_rise = bus.start & ~start_q;
   // Collision masks the counter so a terminal-count edge cannot also pulse.
   assign tick_en    = (state_q == S_RUN) & ~bus.collision;

   move_tick_gen #(
      .PERIOD_W (PERIOD_W)
   ) u_tick (
      .clk      (clk),
      .reset    (reset),
      .enable_i (tick_en),
      .clear_i  (reinit),
      .period_i (period_q),
      .tick_o   (tick),
      .wrap_o   (wrap)
   );

   always_comb begin
      state_d  = state_q;
      level_d  = level_q;
      period_d = period_q;
      mcnt_d   = mcnt_q;
      reinit   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_rise) begin
               state_d = S_RUN;
               reinit  = 1'b1;
            end
         end
         S_RUN: begin
            if (bus.collision) begin
               state_d = S_OVER;
            end else if (wrap) begin
               if (mcnt_q == MCNT_LAST) begin
                  mcnt_d   = '0;
                  level_d  = (level_q < LEVEL_TOP) ? level_q + LEVEL_W'(1) : level_q;
                  period_d = PERIOD_W'(dec_period(32'(period_q),
                                                  int'(MIN_PERIOD),
                                                  int'(PERIOD_STEP)));
               end else begin
                  mcnt_d = mcnt_q + MCNT_W'(1);
               end
            end
         end
         S_OVER: begin
            if (start_rise) begin
               state_d = S_RUN;
               reinit  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (reinit) begin
         level_d  = '0;
         period_d = PERIOD_INIT;
         mcnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         start_q  <= 1'b0;
         level_q  <= '0;
         period_q <= PERIOD_INIT;
         mcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         start_q  <= bus.start;
         level_q  <= level_d;
         period_q <= period_d;
         mcnt_q   <= mcnt_d;
      end
   end

   assign bus.move      = tick;
   assign bus.running   = (state_q == S_RUN);
   assign bus.game_over = (state_q == S_OVER);
   assign bus.level     = level_q;

endmodule

`default_nettype wire

// File: tb/tb_move_scheduler.sv
// ---------------------------------------------------------------------------
// tb_move_scheduler: randomized + directed stimulus against a game-rule model;
// expected outputs are queued per edge and popped by a separate monitor.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_move_scheduler;
   import game_pkg::*;

   localparam int PW   = 8;
   localparam int INIT = 4;
   localparam int MINP = 2;
   localparam int STEP = 1;
   localparam int MPL  = 3;
   localparam int LMAX = 3;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   move_scheduler_if bus();

   move_scheduler #(
      .PERIOD_W        (PW),
      .INIT_PERIOD     (INIT),
      .MIN_PERIOD      (MINP),
      .PERIOD_STEP     (STEP),
      .MOVES_PER_LEVEL (MPL),
      .LEVEL_MAX       (LMAX)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic mv;
      logic run;
      logic ovr;
      int   lvl;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Game-rule model: mode 0 idle, 1 running, 2 over; ups counts every level-up.
   int   m_mode    = 0;
   int   m_elapsed = 0;
   int   m_pulses  = 0;
   int   m_ups     = 0;
   logic m_prev    = 1'b0;

   function automatic int m_period();
      int p;
      p = INIT - STEP * m_ups;
      return (p < MINP) ? MINP : p;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("move",      {31'b0, bus.move},      {31'b0, e.mv});
         chk("running",   {31'b0, bus.running},   {31'b0, e.run});
         chk("game_over", {31'b0, bus.game_over}, {31'b0, e.ovr});
         chk("level",     32'(bus.level),         32'(e.lvl));
      end
   end

   task automatic model(input logic r, input logic s, input logic c, output exp_t e);
      logic rise;
      logic mv;
      mv = 1'b0;
      if (r) begin
         m_mode = 0; m_elapsed = 0; m_pulses = 0; m_ups = 0; m_prev = 1'b0;
      end else begin
         rise   = s && !m_prev;
         m_prev = s;
         if (m_mode == 1) begin
            if (c) begin
               m_mode = 2;
            end else if (m_elapsed == m_period() - 1) begin
               mv        = 1'b1;
               m_elapsed = 0;
               m_pulses++;
               if (m_pulses == MPL) begin
                  m_pulses = 0;
                  m_ups++;
               end
            end else begin
               m_elapsed++;
            end
         end else if (rise) begin
            m_mode = 1; m_elapsed = 0; m_pulses = 0; m_ups = 0;
         end
      end
      e.mv  = mv;
      e.run = (m_mode == 1);
      e.ovr = (m_mode == 2);
      e.lvl = (m_ups > LMAX) ? LMAX : m_ups;
   endtask

   task automatic cyc(input logic r, input logic s, input logic c);
      exp_t e;
      reset         = r;
      bus.start     = s;
      bus.collision = c;
      model(r, s, c, e);
      @(posedge clk);
      exp_q.push_back(e);
      #1;
   endtask

   // Idle-run until the coming edge is 'off' cycles before a terminal count.
   task automatic wait_term(input int off, input logic s);
      int n;
      n = 0;
      while (!(m_mode == 1 && m_elapsed == m_period() - 1 - off) && n < 100) begin
         cyc(1'b0, s, 1'b0);
         n++;
      end
      if (n >= 100) begin
         errors++;
         $display("FAIL wait_term timeout: elapsed %0d required %0d", m_elapsed, m_period() - 1 - off);
      end
   endtask

   initial begin
      logic s;
      logic c;
      logic r;
      bus.start     = 1'b0;
      bus.collision = 1'b0;

      repeat (3) cyc(1'b1, 1'b0, 1'b0);
      repeat (20) cyc(1'b0, 1'b0, 1'b0);

      cyc(1'b0, 1'b1, 1'b0);
      repeat (80) cyc(1'b0, 1'b0, 1'b0);

      wait_term(0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      repeat (20) cyc(1'b0, 1'b0, 1'b0);

      cyc(1'b0, 1'b1, 1'b0);
      repeat (30) cyc(1'b0, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, 1'b1, 1'b0);
      wait_term(0, 1'b1);
      cyc(1'b0, 1'b1, 1'b1);
      repeat (10) cyc(1'b0, 1'b1, 1'b0);
      repeat (2) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      repeat (20) cyc(1'b0, 1'b0, 1'b0);

      wait_term(1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      repeat (5) cyc(1'b0, 1'b0, 1'b0);

      s = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) s = ~s;
         c = ($urandom_range(39) == 0);
         r = ($urandom_range(299) == 0);
         cyc(r, s, c);
      end

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
